dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the 4-lane byte-sliced data memory between the processor execute stage and a debug/display port, so the display path can read or write any word at run time instead of relying on fixed taps. The CPU has priority. A starvation counter guarantees debug progress by stalling the pipeline for one cycle. The block sits between the execute stage / ew_reg boundary and the data_mem lanes.

Parameters:
ADDR_W, 8, word address width presented to data_mem
STARVE_LIMIT, 15, consecutive denied debug-request cycles before the debug port is forced through (1..255)
CNT_W, 16, width of saturating stall statistics counter

Ports:
sysclk  in  1  clock; all state updates on rising edge
cpu_resetn  in  1  asynchronous active-low reset
cpu_valid  in  1  execute stage performs a load/store this cycle
cpu_addr  in  ADDR_W  CPU word address
cpu_wren  in  4  CPU byte-lane write enables
cpu_wdata  in  32  CPU store data
cpu_rdata  out  32  load data to execute stage (mem_rdata passthrough)
cpu_stall  out  1  hold pipeline (fd/de/ew regs and pc) this cycle
cpu_halt  in  1  halt opcode reached write stage; CPU no longer uses memory
dbg_req  in  1  debug access request, level, held until dbg_ack
dbg_we  in  1  1 = full-word write, 0 = read
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  32  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  32  registered read data, valid while dbg_ack=1, held until next debug read
mem_addr  out  ADDR_W  to all four data_mem lanes
mem_wren  out  4  per-lane write enable
mem_wdata  out  32  lane write data
mem_rdata  in  32  combinational read data from lanes
stall_count  out  CNT_W  saturating count of cycles with cpu_stall=1

Behaviour:
- Reset: all outputs and state asynchronously cleared: state=IDLE, dbg_ack=0, dbg_rdata=0, starve_cnt=0, stall_count=0. While cpu_resetn=0, mem_wren=0 and cpu_stall=0 (combinationally forced).
- cpu_act = cpu_valid & ~cpu_halt. When cpu_halt=1, CPU requests are ignored and are never stalled.
- States: IDLE, ACK.
- IDLE, grant_dbg (combinational) = dbg_req & (~cpu_act | starve_cnt==STARVE_LIMIT).
  - grant_dbg=1: mem_addr=dbg_addr, mem_wren = dbg_we ? 4'b1111 : 4'b0000, mem_wdata=dbg_wdata. If dbg_we=0, dbg_rdata <= mem_rdata at the edge. cpu_stall=cpu_act. starve_cnt <= 0. next=ACK.
  - grant_dbg=0: mem_* driven from cpu_* (mem_wren=cpu_wren when cpu_act, else 0). If dbg_req=1 and cpu_act=1, starve_cnt <= starve_cnt+1 (saturates at STARVE_LIMIT). If dbg_req=0, starve_cnt <= 0.
- ACK: dbg_ack=1 for exactly this cycle. The memory belongs to the CPU (CPU-source mux, as above). dbg_req is ignored. next=IDLE unconditionally. A held dbg_req in the following IDLE cycle is a new request. Maximum debug rate: one access every 2 cycles.
- cpu_rdata = mem_rdata always. It is only meaningful to the CPU when cpu_stall=0.
- A debug write stalls a concurrent CPU store, so no store is lost. The CPU re-presents the same access next cycle because the pipeline is held.
- Latency: debug read with idle CPU: req seen in cycle N, dbg_ack and data in cycle N+1. Worst case with a continuously busy CPU: STARVE_LIMIT+2 cycles.
- stall_count increments on every cycle cpu_stall=1. It saturates at all-ones and never wraps.
- Reset asserted mid-access: the access is aborted, no write occurs, no dbg_ack is produced after release, and the requester must re-issue.

Test Plan:
- Reset then idle: cpu_valid=0, dbg_req=1, dbg_we=0, dbg_addr=8'h85, mem holds 32'h00000315 -> next cycle dbg_ack=1, dbg_rdata=32'h00000315, cpu_stall never asserted, stall_count=0.
- Debug write: dbg_we=1, dbg_addr=8'h90, dbg_wdata=32'd97, cpu idle -> mem_wren=4'hF for one cycle. A subsequent debug read of 8'h90 returns 97.
- Starvation: cpu_valid=1 every cycle, dbg_req held, STARVE_LIMIT=15 -> debug denied for 15 cycles. On the 16th cycle grant_dbg=1 and cpu_stall=1 for one cycle, dbg_ack in the 17th, stall_count=1.
- Halt: cpu_halt=1, cpu_valid=1, cpu_wren=4'hF, dbg_req=1 -> debug granted immediately, CPU mem_wren never driven, cpu_stall=0.
- Back-to-back: dbg_req held high for 6 cycles with CPU idle -> dbg_ack pulses in cycles 2, 4, 6. Requests in ACK cycles are ignored.
- Reset mid-grant: assert cpu_resetn=0 in the grant cycle -> mem_wren=0 immediately, no dbg_ack after release, starve_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the execute stage, the debug/display port and the data_mem lanes.
// The slave side is the arbiter; the master side is the surrounding CPU/debug/memory environment.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [3:0]        cpu_wren;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              cpu_halt;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wren;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wren, cpu_wdata, cpu_halt,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_addr, mem_wren, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wren, cpu_wdata, cpu_halt,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_addr, mem_wren, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the byte-sliced data memory between the execute stage (priority) and the debug port;
// a starvation counter forces a debug access through by stalling the pipeline for one cycle.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             sysclk,
    input  logic             cpu_resetn,
    dmem_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state, state_nxt;
    logic [7:0]  starve_cnt;
    logic [31:0] dbg_rdata_q;
    logic        cpu_act;
    logic        grant_dbg;
    logic        stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] starve_inc(input logic [7:0] v);
        return (v >= LIMIT) ? LIMIT : v + 8'd1;
    endfunction

    assign cpu_act   = bus.cpu_valid & ~bus.cpu_halt;
    assign grant_dbg = (state == IDLE) & bus.dbg_req & (~cpu_act | (starve_cnt == LIMIT));

    always_comb begin
        state_nxt     = state;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wren  = cpu_act ? bus.cpu_wren : 4'b0000;
        bus.mem_wdata = bus.cpu_wdata;
        stall         = 1'b0;
        case (state)
            IDLE: begin
                if (grant_dbg) begin
                    bus.mem_addr  = bus.dbg_addr;
                    bus.mem_wren  = bus.dbg_we ? 4'b1111 : 4'b0000;
                    bus.mem_wdata = bus.dbg_wdata;
                    stall         = cpu_act;
                    state_nxt     = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // An aborted access must never reach the lanes, even within the reset cycle itself.
        if (!cpu_resetn) begin
            bus.mem_wren = 4'b0000;
            stall        = 1'b0;
        end
    end

    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dbg_ack   = (state == ACK);
    assign bus.dbg_rdata = dbg_rdata_q;

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state       <= IDLE;
            starve_cnt  <= 8'd0;
            dbg_rdata_q <= 32'd0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (grant_dbg || !bus.dbg_req)
                    starve_cnt <= 8'd0;
                else if (cpu_act)
                    starve_cnt <= starve_inc(starve_cnt);
            end
            if (grant_dbg && !bus.dbg_we)
                dbg_rdata_q <= bus.mem_rdata;
            if (stall)
                stall_count <= sat_inc(stall_count);
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus queues expected debug completions, a monitor pops them on dbg_ack.
module tb_dmem_arbiter;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 2;

    logic             sysclk = 1'b0;
    logic             cpu_resetn;
    logic [CNT_W-1:0] stall_count;
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;

    typedef struct {
        int          cyc;
        logic        chk;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    logic [31:0] mem [256];

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(15), .CNT_W(CNT_W)) dut (
        .sysclk      (sysclk),
        .cpu_resetn  (cpu_resetn),
        .bus         (bus),
        .stall_count (stall_count)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge sysclk) begin
        for (int i = 0; i < 4; i++)
            if (bus.mem_wren[i]) mem[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Monitor: every dbg_ack must match the oldest outstanding expectation, and none may be overdue.
    always @(negedge sysclk) begin
        exp_t e;
        if (bus.dbg_ack === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                if (e.chk) chk("dbg_rdata", bus.dbg_rdata, e.data);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("missed_ack", cyc, e.cyc);
        end
    end

    task automatic dbg_read(input logic [7:0] a, input logic [31:0] exp);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = a;
        q.push_back('{cyc + 1, 1'b1, exp});
        #1;
        chk("read_grant_stall", bus.cpu_stall, 1'b0);
        step();
        bus.dbg_req = 1'b0;
        step();
    endtask

    task automatic starve_round(input logic [31:0] exp_count);
        bus.cpu_valid = 1'b1; bus.cpu_wren = 4'h0; bus.cpu_addr = 8'h20;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h85;
        q.push_back('{cyc + 16, 1'b1, 32'h0000_0315});
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("starve_deny_stall", bus.cpu_stall, 1'b0);
            step();
        end
        #1;
        chk("starve_grant_stall", bus.cpu_stall, 1'b1);
        chk("starve_grant_addr", bus.mem_addr, 8'h85);
        step();
        bus.dbg_req = 1'b0;
        #1;
        chk("starve_ack_stall", bus.cpu_stall, 1'b0);
        chk("stall_count", stall_count, exp_count);
        bus.cpu_valid = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[8'h85] = 32'h0000_0315;
        mem[8'h10] = 32'h1122_3344;
        mem[8'h40] = 32'h0000_1234;

        cpu_resetn    = 1'b0;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 8'h00; bus.cpu_wren = 4'hF; bus.cpu_wdata = 32'h0;
        bus.cpu_halt  = 1'b0;
        bus.dbg_req   = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00; bus.dbg_wdata = 32'h0;

        // Reset state
        step(); step();
        chk("rst_mem_wren", bus.mem_wren, 4'h0);
        chk("rst_cpu_stall", bus.cpu_stall, 1'b0);
        chk("rst_dbg_ack", bus.dbg_ack, 1'b0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
        chk("rst_stall_count", stall_count, 0);
        bus.cpu_valid = 1'b0; bus.cpu_wren = 4'h0;
        #2 cpu_resetn = 1'b1;
        step();

        // Debug read with CPU idle
        dbg_read(8'h85, 32'h0000_0315);
        chk("idle_stall_count", stall_count, 0);

        // Debug write, then read back
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h90; bus.dbg_wdata = 32'd97;
        q.push_back('{cyc + 1, 1'b0, 32'h0});
        #1;
        chk("wr_mem_wren", bus.mem_wren, 4'hF);
        chk("wr_mem_wdata", bus.mem_wdata, 32'd97);
        step();
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        #1;
        chk("wr_ack_mem_wren", bus.mem_wren, 4'h0);
        step();
        dbg_read(8'h90, 32'd97);

        // CPU passthrough with partial-lane store
        bus.cpu_valid = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wren = 4'b0011; bus.cpu_wdata = 32'hAABB_CCDD;
        #1;
        chk("cpu_mem_addr", bus.mem_addr, 8'h10);
        chk("cpu_mem_wren", bus.mem_wren, 4'b0011);
        chk("cpu_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
        chk("cpu_rdata_pre", bus.cpu_rdata, 32'h1122_3344);
        step();
        bus.cpu_wren = 4'h0;
        #1;
        chk("cpu_rdata_post", bus.cpu_rdata, 32'h1122_CCDD);
        bus.cpu_valid = 1'b0;
        step();

        // Starvation with a continuously busy CPU
        starve_round(1);

        // Halted CPU is ignored and never stalled
        bus.cpu_halt = 1'b1; bus.cpu_valid = 1'b1; bus.cpu_wren = 4'hF; bus.cpu_addr = 8'h30;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h85;
        q.push_back('{cyc + 1, 1'b1, 32'h0000_0315});
        #1;
        chk("halt_grant_stall", bus.cpu_stall, 1'b0);
        chk("halt_grant_wren", bus.mem_wren, 4'h0);
        chk("halt_grant_addr", bus.mem_addr, 8'h85);
        step();
        bus.dbg_req = 1'b0;
        #1;
        chk("halt_ack_wren", bus.mem_wren, 4'h0);
        chk("halt_ack_stall", bus.cpu_stall, 1'b0);
        bus.cpu_halt = 1'b0; bus.cpu_valid = 1'b0; bus.cpu_wren = 4'h0;
        step();

        // Back-to-back requests: one access every two cycles
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h90;
        q.push_back('{cyc + 1, 1'b1, 32'd97});
        q.push_back('{cyc + 3, 1'b1, 32'd97});
        q.push_back('{cyc + 5, 1'b1, 32'd97});
        for (int i = 0; i < 6; i++) step();
        bus.dbg_req = 1'b0;
        step();

        // Reset asserted during a debug write grant
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h40; bus.dbg_wdata = 32'h0000_DEAD;
        #1;
        chk("mid_grant_wren", bus.mem_wren, 4'hF);
        cpu_resetn = 1'b0;
        #1;
        chk("mid_rst_wren", bus.mem_wren, 4'h0);
        chk("mid_rst_stall", bus.cpu_stall, 1'b0);
        step();
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        #2 cpu_resetn = 1'b1;
        step(); step(); step();
        chk("mid_rst_stall_count", stall_count, 0);
        dbg_read(8'h40, 32'h0000_1234);

        // Stall counter saturates rather than wrapping
        starve_round(1);
        starve_round(2);
        starve_round(3);
        starve_round(3);

        step(); step();
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
